cdc_strobe_traffic_gen: RTL and testbench

//  Synthesisable, parametrised strobe traffic generator for the source side of the CDC

---
 rtl/cdc_strobe_traffic_gen.sv | 208 ++++++++++++++++++++
 tb/tb_cdc_strobe_traffic_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_strobe_traffic_gen.sv
// cdc_strobe_traffic_gen
// Source-side strobe traffic generator for the CDC strobe/stall handshake.
// Each of CHANNELS lanes issues burst_len single-cycle strobes, honouring its own
// source_stall, with a programmable idle gap between strobes. A global done pulse
// marks the cycle in which every lane has finished.
//
// Handshake semantics: a strobe is issued (source_strobe registered high for one cycle)
// only from a cycle in which source_stall for that lane is low; after a strobe the lane
// holds at least two cycles and leaves HOLD only in a cycle with source_stall low.
//
// Optional feature macro: STROBE_GEN_RAND_GAP_EN
//   defined   : a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) free-runs from
//               LFSR_SEED; each gap is LFSR[GAP_W-1:0] & gap_cycles (GAP_W <= 16).
//   undefined : every gap is exactly gap_cycles and no LFSR is built.
//
// dbg_chan_state exposes every lane's FSM state, 3 bits per lane.

module cdc_strobe_traffic_gen #(
    parameter int              CHANNELS  = 4,
    parameter int              CNT_W     = 16,
    parameter int              GAP_W     = 8,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic                        source_clk,
    input  logic                        source_reset_n,
    input  logic                        start,
    input  logic [CHANNELS-1:0]         chan_en,
    input  logic [CNT_W-1:0]            burst_len,
    input  logic [GAP_W-1:0]            gap_cycles,
    input  logic [CHANNELS-1:0]         source_stall,
    output logic [CHANNELS-1:0]         source_strobe,
    output logic [CHANNELS*CNT_W-1:0]   sent_count,
    output logic                        busy,
    output logic                        done,
    output logic [CHANNELS*3-1:0]       dbg_chan_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } chan_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chan_state_t         state_q   [CHANNELS];
    chan_state_t         state_d   [CHANNELS];
    logic [CNT_W-1:0]    rem_q     [CHANNELS];
    logic [CNT_W-1:0]    rem_d     [CHANNELS];
    logic [CNT_W-1:0]    sent_q    [CHANNELS];
    logic [CNT_W-1:0]    sent_d    [CHANNELS];
    logic [GAP_W-1:0]    gap_cnt_q [CHANNELS];
    logic [GAP_W-1:0]    gap_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] hold_first_q, hold_first_d;
    logic [CHANNELS-1:0] strobe_q, strobe_d;
    logic [GAP_W-1:0]    gap_cfg_q, gap_cfg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                all_fin;
    logic [GAP_W-1:0]    gap_eff;

`ifdef STROBE_GEN_RAND_GAP_EN
    logic [15:0]         lfsr_q, lfsr_d;
    logic                lfsr_fb;
`endif

    // Next-state logic for the global control and every lane FSM.
    always_comb begin
        // The done cycle is excluded so lanes leave FIN before a new burst starts.
        accept    = start && !busy_q && !done_q;
        gap_cfg_d = accept ? gap_cycles : gap_cfg_q;

`ifdef STROBE_GEN_RAND_GAP_EN
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
        gap_eff = lfsr_q[GAP_W-1:0] & gap_cfg_q;
`else
        gap_eff = gap_cfg_q;
`endif

        strobe_d     = '0;
        hold_first_d = hold_first_q;
        all_fin      = 1'b1;

        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            rem_d[i]     = rem_q[i];
            sent_d[i]    = sent_q[i];
            gap_cnt_d[i] = gap_cnt_q[i];

            case (state_q[i])
                ST_IDLE: begin
                    if (accept) begin
                        sent_d[i] = '0;
                        rem_d[i]  = burst_len;
                        if (chan_en[i] && (burst_len != '0)) begin
                            state_d[i] = ST_ISSUE;
                        end else begin
                            state_d[i] = ST_FIN;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!source_stall[i]) begin
                        strobe_d[i]     = 1'b1;
                        rem_d[i]        = rem_q[i] - CNT_ONE;
                        hold_first_d[i] = 1'b1;
                        state_d[i]      = ST_HOLD;
                        if (sent_q[i] != CNT_MAX) begin
                            sent_d[i] = sent_q[i] + CNT_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    // First HOLD cycle is unconditional so a stall raised in
                    // response to the strobe is seen before the lane moves on.
                    if (hold_first_q[i]) begin
                        hold_first_d[i] = 1'b0;
                    end else if (!source_stall[i]) begin
                        if (gap_eff != '0) begin
                            gap_cnt_d[i] = gap_eff;
                            state_d[i]   = ST_GAP;
                        end else if (rem_q[i] != '0) begin
                            state_d[i] = ST_ISSUE;
                        end else begin
                            state_d[i] = ST_FIN;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q[i] <= GAP_ONE) begin
                        state_d[i] = (rem_q[i] != '0) ? ST_ISSUE : ST_FIN;
                    end else begin
                        gap_cnt_d[i] = gap_cnt_q[i] - GAP_ONE;
                    end
                end
                ST_FIN: begin
                    if (done_q) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            if (state_d[i] != ST_FIN) begin
                all_fin = 1'b0;
            end
        end

        done_d = busy_q && all_fin;
        busy_d = accept || (busy_q && !all_fin);
    end

    // State registers; reset aborts every lane immediately.
    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= ST_IDLE;
                rem_q[i]     <= '0;
                sent_q[i]    <= '0;
                gap_cnt_q[i] <= '0;
            end
            hold_first_q <= '0;
            strobe_q     <= '0;
            gap_cfg_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef STROBE_GEN_RAND_GAP_EN
            lfsr_q       <= LFSR_SEED;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= state_d[i];
                rem_q[i]     <= rem_d[i];
                sent_q[i]    <= sent_d[i];
                gap_cnt_q[i] <= gap_cnt_d[i];
            end
            hold_first_q <= hold_first_d;
            strobe_q     <= strobe_d;
            gap_cfg_q    <= gap_cfg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef STROBE_GEN_RAND_GAP_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    // Output packing of per-lane registers.
    always_comb begin
        source_strobe = strobe_q;
        busy          = busy_q;
        done          = done_q;
        for (int i = 0; i < CHANNELS; i++) begin
            sent_count[i*CNT_W +: CNT_W] = sent_q[i];
            dbg_chan_state[i*3 +: 3]     = state_q[i];
        end
    end

endmodule

// File: tb/tb_cdc_strobe_traffic_gen.sv
// Testbench for cdc_strobe_traffic_gen (default parameters, 4 channels).
// The reference model derives each lane's strobe cycles from the stall pattern:
// a strobe follows the first stall-free cycle at or after the lane is ready to issue,
// the lane then needs a stall-free cycle at least two cycles after that, followed by
// the gap, before it is ready again. done lands on max(T+2, last lane finish).

module tb_cdc_strobe_traffic_gen;

    localparam int CH   = 4;
    localparam int CW   = 16;
    localparam int GW   = 8;
    localparam int MAXC = 6000;

    logic              source_clk = 1'b0;
    logic              source_reset_n = 1'b0;
    logic              start = 1'b0;
    logic [CH-1:0]     chan_en = '0;
    logic [CW-1:0]     burst_len = '0;
    logic [GW-1:0]     gap_cycles = '0;
    logic [CH-1:0]     source_stall = '0;
    logic [CH-1:0]     source_strobe;
    logic [CH*CW-1:0]  sent_count;
    logic              busy;
    logic              done;
    logic [CH*3-1:0]   dbg_chan_state;

    cdc_strobe_traffic_gen dut (
        .source_clk     (source_clk),
        .source_reset_n (source_reset_n),
        .start          (start),
        .chan_en        (chan_en),
        .burst_len      (burst_len),
        .gap_cycles     (gap_cycles),
        .source_stall   (source_stall),
        .source_strobe  (source_strobe),
        .sent_count     (sent_count),
        .busy           (busy),
        .done           (done),
        .dbg_chan_state (dbg_chan_state)
    );

    // Clock and cycle bookkeeping
    always #5 source_clk = ~source_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [CH-1:0]  stall_pat  [MAXC];
    logic [CH-1:0]  exp_strobe [MAXC];
    logic [CW-1:0]  exp_sent   [MAXC][CH];
    logic           exp_busy   [MAXC];
    logic           exp_done   [MAXC];
    logic [15:0]    lfsr_at    [MAXC];
    logic [31:0]    exp_q[$];
    logic [31:0]    done_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic int gap_at(input int u, input int gap);
`ifdef STROBE_GEN_RAND_GAP_EN
        logic [15:0] l;
        l = lfsr_at[u];
        return int'(l[7:0] & 8'(gap));
`else
        if (u < 0) return 0;
        return gap;
`endif
    endfunction

    // LFSR value per cycle, starting from the cycle reset is released.
    task automatic fill_lfsr(input int from);
        lfsr_at[from] = 16'hACE1;
        for (int t = from + 1; t < MAXC; t++) lfsr_at[t] = lfsr_step(lfsr_at[t-1]);
    endtask

    // Stall stimulus: 0 = none, 1 = random (25%), 2 = channel 1 high for 20 cycles.
    task automatic set_stall(input int from, input int mode);
        for (int t = from; t < MAXC; t++) begin
            for (int c = 0; c < CH; c++) begin
                case (mode)
                    1:       stall_pat[t][c] = ($urandom_range(0, 3) == 0);
                    2:       stall_pat[t][c] = (c == 1) && (t < from + 20);
                    default: stall_pat[t][c] = 1'b0;
                endcase
            end
        end
    endtask

    // Reset wipes every expectation from cycle r onward.
    task automatic truncate(input int r);
        logic [31:0] keep[$];
        for (int t = r; t < MAXC; t++) begin
            exp_strobe[t] = '0;
            exp_busy[t]   = 1'b0;
            exp_done[t]   = 1'b0;
            for (int c = 0; c < CH; c++) exp_sent[t][c] = '0;
        end
        keep = {};
        foreach (exp_q[k]) if (exp_q[k] < 32'(r)) keep.push_back(exp_q[k]);
        exp_q = keep;
    endtask

    // Reference model for one accepted burst started in cycle t0.
    task automatic model_burst(input int t0, input logic [CH-1:0] en, input int len,
                               input int gap, output int d);
        int fin_max, t, u, ti, cnt;
        fin_max = t0 + 2;
        for (int c = 0; c < CH; c++) begin
            for (int tt = t0 + 1; tt < MAXC; tt++) exp_sent[tt][c] = '0;
            if (en[c] && len != 0) begin
                ti  = t0 + 1;
                cnt = 0;
                for (int k = 0; k < len; k++) begin
                    t = ti;
                    while (t < MAXC - 4 && stall_pat[t][c]) t++;
                    if (t + 1 < MAXC) exp_strobe[t+1][c] = 1'b1;
                    cnt++;
                    for (int tt = t + 1; tt < MAXC; tt++) exp_sent[tt][c] = CW'(cnt);
                    u = t + 2;
                    while (u < MAXC - 4 && stall_pat[u][c]) u++;
                    ti = u + 1 + gap_at(u, gap);
                end
                if (ti > fin_max) fin_max = ti;
            end
        end
        d = fin_max;
        for (int tt = t0 + 1; tt < d && tt < MAXC; tt++) exp_busy[tt] = 1'b1;
        if (d < MAXC) exp_done[d] = 1'b1;
        exp_q.push_back(32'(d));
    endtask

    // Driver tasks
    task automatic next_cycle();
        @(posedge source_clk);
        cyc++;
        #1;
        start = 1'b0;
        if (cyc < MAXC) source_stall = stall_pat[cyc];
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic start_burst(input logic [CH-1:0] en, input int len, input int gap,
                               input int mode, output int t0, output int d);
        set_stall(cyc + 1, mode);
        next_cycle();
        t0         = cyc;
        start      = 1'b1;
        chan_en    = en;
        burst_len  = CW'(len);
        gap_cycles = GW'(gap);
        model_burst(t0, en, len, gap, d);
        if (d >= MAXC - 2) begin
            $display("FAIL cycle_budget cycle=%0d got=%0d expected<%0d", cyc, d, MAXC - 2);
            $fatal(1);
        end
    endtask

    // Scoreboard: compare every cycle against the model.
    always @(negedge source_clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            check("source_strobe", 32'(source_strobe), 32'(exp_strobe[cyc]));
            check("busy", 32'(busy), 32'(exp_busy[cyc]));
            check("done", 32'(done), 32'(exp_done[cyc]));
            for (int c = 0; c < CH; c++)
                check("sent_count", 32'(sent_count[c*CW +: CW]), 32'(exp_sent[cyc][c]));
            if (done === 1'b1) begin
                done_exp = 32'hFFFF_FFFF;
                if (exp_q.size() > 0) done_exp = exp_q.pop_front();
                check("done_cycle", 32'(cyc), done_exp);
            end
        end
    end

    // Stimulus sequence
    initial begin : main
        int t0, d, r, len6;
        for (int t = 0; t < MAXC; t++) begin
            stall_pat[t]  = '0;
            exp_strobe[t] = '0;
            exp_busy[t]   = 1'b0;
            exp_done[t]   = 1'b0;
            lfsr_at[t]    = 16'hACE1;
            for (int c = 0; c < CH; c++) exp_sent[t][c] = '0;
        end

        // Reset held 5 cycles, then idle with no start.
        wait_until(5);
        source_reset_n = 1'b1;
        fill_lfsr(5);
        wait_until(12);

        // Single channel, len 3, gap 0.
        start_burst(4'b0001, 3, 0, 0, t0, d);
        check("pin2_strobe_a", 32'(exp_strobe[t0+2][0]), 32'd1);
        check("pin2_strobe_b", 32'(exp_strobe[t0+5][0]), 32'd1);
        check("pin2_strobe_c", 32'(exp_strobe[t0+8][0]), 32'd1);
        check("pin2_no_strobe", 32'(exp_strobe[t0+3][0]), 32'd0);
        check("pin2_done", 32'(d - t0), 32'd10);
        check("pin2_sent", 32'(exp_sent[d][0]), 32'd3);
        wait_until(d);

        // Two channels, channel 1 stalled 20 cycles from start.
        start_burst(4'b0011, 2, 4, 2, t0, d);
`ifndef STROBE_GEN_RAND_GAP_EN
        check("pin3_ch0_second", 32'(exp_strobe[t0+9][0]), 32'd1);
        check("pin3_ch1_first", 32'(exp_strobe[t0+21][1]), 32'd1);
        check("pin3_ch1_second", 32'(exp_strobe[t0+28][1]), 32'd1);
        check("pin3_done", 32'(d - t0), 32'd34);
`endif
        wait_until(d);

        // Start while busy is ignored.
        start_burst(4'b0110, 3, 1, 0, t0, d);
        wait_until(t0 + 3);
        start      = 1'b1;
        chan_en    = 4'hF;
        burst_len  = 16'd9;
        gap_cycles = 8'd0;
        wait_until(d);

        // len 0 and chan_en 0: done at T+2 with no strobe.
        start_burst(4'b1111, 0, 3, 0, t0, d);
        check("pin4_len0_done", 32'(d - t0), 32'd2);
        check("pin4_len0_strobe", 32'(exp_strobe[t0+2]), 32'd0);
        wait_until(d);
        start_burst(4'b0000, 4, 0, 0, t0, d);
        check("pin4_en0_done", 32'(d - t0), 32'd2);
        wait_until(d);

        // Reset after the first of 5 strobes.
        start_burst(4'b0001, 5, 2, 0, t0, d);
        check("pin5_first", 32'(exp_strobe[t0+2][0]), 32'd1);
        wait_until(t0 + 3);
        source_reset_n = 1'b0;
        r = cyc;
        truncate(r);
        wait_until(r + 3);
        source_reset_n = 1'b1;
        fill_lfsr(cyc);
        wait_until(r + 12);
        start_burst(4'b0001, 5, 2, 0, t0, d);
`ifndef STROBE_GEN_RAND_GAP_EN
        check("pin5_done", 32'(d - t0), 32'd26);
`endif
        check("pin5_sent", 32'(exp_sent[d][0]), 32'd5);
        wait_until(d);

        // Maximum gap.
`ifdef STROBE_GEN_RAND_GAP_EN
        len6 = 8;
`else
        len6 = 2;
`endif
        start_burst(4'b0001, len6, 255, 0, t0, d);
`ifndef STROBE_GEN_RAND_GAP_EN
        check("pin6_second", 32'(exp_strobe[t0+260][0]), 32'd1);
        check("pin6_done", 32'(d - t0), 32'd517);
`endif
        wait_until(d);

        // Randomized bursts with random stall.
        for (int n = 0; n < 25; n++) begin
            start_burst(4'($urandom_range(0, 15)), $urandom_range(0, 6),
                        $urandom_range(0, 5), $urandom_range(0, 1), t0, d);
            wait_until(d);
        end

        set_stall(cyc + 1, 0);
        wait_until(cyc + 5);
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
